// File: rtl/imem_boot_loader_pkg.sv
// Shared types and widths for the boot-time instruction-memory loader.
package boot_pkg;

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_W  = 16;
  localparam int CSUM_W = 8;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, imem write port and load status of the boot loader.
interface imem_boot_loader_if
  import boot_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_error;
  logic [HDR_W-1:0]  word_count;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  core_reset,
    input  load_done,
    input  load_error,
    input  word_count
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output core_reset,
    output load_done,
    output load_error,
    output word_count
  );

endinterface

// File: rtl/imem_boot_loader_assembler.sv
// Packs stream bytes little-endian into 32-bit words and keeps a running XOR.
module byte_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [7:0]        i_byte,
  output logic              o_word_valid,
  output logic [31:0]       o_word,
  output logic [CSUM_W-1:0] o_csum
);

  logic [1:0]        r_idx;
  logic [23:0]       r_shift;
  logic [CSUM_W-1:0] r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
    end else if (i_en) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
      r_acc   <= r_acc ^ i_byte;
    end
  end

  // The 4th byte completes the word this cycle; the caller registers it.
  assign o_word_valid = i_en && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_shift};
  assign o_csum       = r_acc;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked image into imem, then releases the core.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10,
  parameter int BASE_WORD  = 2
) (
  input logic               clk,
  input logic               reset,
  imem_boot_loader_if.slave bus
);

  localparam logic [HDR_W-1:0] MAX_N =
    HDR_W'(IMEM_DEPTH - BASE_WORD);

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_cnt_lo;
  logic [HDR_W-1:0]   r_n;
  logic [HDR_W-1:0]   r_wc;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               r_core_reset;
  logic               r_done;
  logic               r_err;

  logic               w_xfer;
  logic               w_asm_en;
  logic               w_word_valid;
  logic [31:0]        w_word;
  logic [CSUM_W-1:0]  w_csum;
  logic [HDR_W-1:0]   w_hdr;
  logic               w_last;

  assign bus.rx_ready = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer       = bus.rx_valid && bus.rx_ready;
  assign w_asm_en     = w_xfer && (r_state == S_DATA);
  assign w_hdr        = {bus.rx_data, r_cnt_lo};
  assign w_last       = w_word_valid && ((r_wc + 16'd1) == r_n);

  byte_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_asm_en),
    .i_byte       (bus.rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_csum       (w_csum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HDR_LO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HDR_LO: if (w_xfer) w_next = S_HDR_HI;
      S_HDR_HI: begin
        if (w_xfer) begin
          if (w_hdr > MAX_N)      w_next = S_ERR;
          else if (w_hdr == '0)   w_next = S_CSUM;
          else                    w_next = S_DATA;
        end
      end
      S_DATA:   if (w_last) w_next = S_CSUM;
      S_CSUM: begin
        if (w_xfer)
          w_next = (bus.rx_data == w_csum) ? S_DONE : S_ERR;
      end
      S_DONE:   w_next = S_DONE;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_lo     <= '0;
      r_n          <= '0;
      r_wc         <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we <= w_word_valid;
      if (w_xfer && (r_state == S_HDR_LO)) r_cnt_lo <= bus.rx_data;
      if (w_xfer && (r_state == S_HDR_HI)) r_n <= w_hdr;
      if (w_word_valid) begin
        r_addr  <= ADDR_W'(BASE_WORD) + r_wc[ADDR_W-1:0];
        r_wdata <= w_word;
        r_wc    <= r_wc + 16'd1;
      end
      // Terminal states hold, so these flags stay sticky until reset.
      r_done       <= (w_next == S_DONE);
      r_err        <= (w_next == S_ERR);
      r_core_reset <= (w_next != S_DONE);
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_reset = r_core_reset;
  assign bus.load_done  = r_done;
  assign bus.load_error = r_err;
  assign bus.word_count = r_wc;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, bad checksum, empty, overflow, gaps, reset.
module tb_imem_boot_loader;
  import boot_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(10)) bus ();

  imem_boot_loader #(
    .IMEM_DEPTH (1024),
    .ADDR_W     (10),
    .BASE_WORD  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  always @(negedge clk)
    if (bus.imem_we) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end

  logic [7:0] img [14] = '{
    8'h03, 8'h00,
    8'h93, 8'h00, 8'h50, 8'h00,
    8'h13, 8'h01, 8'hA0, 8'h00,
    8'hB3, 8'h81, 8'h20, 8'h00
  };
  logic [31:0] ew [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};
  localparam logic [7:0] CSUM = 8'h63;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_nom(logic [7:0] cs, int maxgap);
    for (int i = 0; i < 14; i++)
      send_byte(img[i], int'($urandom_range(maxgap, 0)));
    send_byte(cs, int'($urandom_range(maxgap, 0)));
  endtask

  task automatic check_writes(string tag);
    chk({tag, "_nwr"}, wa.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), wa[i], 2 + i);
        chk($sformatf("%s_data%0d", tag, i), wd[i], ew[i]);
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wa.delete();
    wd.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", bus.rx_ready, 1);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_core", bus.core_reset, 1);
    chk("rst_done", bus.load_done, 0);
    chk("rst_err", bus.load_error, 0);
    chk("rst_wc", bus.word_count, 0);
    reset = 1'b0;
    @(negedge clk);

    send_nom(CSUM, 0);
    check_writes("nom");
    chk("nom_wc", bus.word_count, 3);
    chk("nom_done", bus.load_done, 1);
    chk("nom_core", bus.core_reset, 0);
    chk("nom_err", bus.load_error, 0);
    chk("nom_ready", bus.rx_ready, 0);

    do_reset();
    send_nom(~CSUM, 0);
    check_writes("bad");
    chk("bad_err", bus.load_error, 1);
    chk("bad_done", bus.load_done, 0);
    chk("bad_core", bus.core_reset, 1);
    chk("bad_ready", bus.rx_ready, 0);

    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("zero_nwr", wa.size(), 0);
    chk("zero_done", bus.load_done, 1);
    chk("zero_core", bus.core_reset, 0);

    do_reset();
    send_byte(8'hFF, 0);
    send_byte(8'h03, 0);
    chk("ovf_err", bus.load_error, 1);
    chk("ovf_ready", bus.rx_ready, 0);
    chk("ovf_core", bus.core_reset, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h55, 0);
    chk("ovf_nwr", wa.size(), 0);

    do_reset();
    send_nom(CSUM, 5);
    check_writes("gap");
    chk("gap_wc", bus.word_count, 3);
    chk("gap_done", bus.load_done, 1);
    chk("gap_core", bus.core_reset, 0);

    do_reset();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    chk("pulse_we", bus.imem_we, 1);
    reset = 1'b1;
    #1;
    chk("pulse_we_async", bus.imem_we, 0);
    chk("pulse_core", bus.core_reset, 1);

    do_reset();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    reset = 1'b1;
    #1;
    chk("mid_we", bus.imem_we, 0);
    chk("mid_core", bus.core_reset, 1);
    chk("mid_wc", bus.word_count, 0);
    chk("mid_ready", bus.rx_ready, 1);
    do_reset();
    send_nom(CSUM, 0);
    check_writes("reload");
    chk("reload_done", bus.load_done, 1);
    chk("reload_core", bus.core_reset, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader that sits upstream of `risc_v_microcontroller`. It receives a program image as a byte stream, assembles little-endian 32-bit instruction words, and writes them into instruction memory starting at word `BASE_WORD`; words 0..1 stay reserved for SP/LR initialisation. It holds the core in reset until the image has loaded and its checksum has verified. This replaces the simulation-only hierarchical preload of `prog.bin`.

## Interface
- `IMEM_DEPTH`, 1024, instruction memory depth in words.
- `ADDR_W`, 10, imem word-address width; must equal clog2(`IMEM_DEPTH`).
- `BASE_WORD`, 2, first imem word written.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs when `rx_valid && rx_ready` at a rising edge.
- `imem_we`  out  1  single-cycle imem write strobe.
- `imem_addr`  out  `ADDR_W`  imem word address.
- `imem_wdata`  out  32  instruction word.
- `core_reset`  out  1  reset to `risc_v_microcontroller`; high until load succeeds.
- `load_done`  out  1  image loaded and checksum matched (sticky).
- `load_error`  out  1  length overflow or checksum mismatch (sticky).
- `word_count`  out  16  words written so far.

## Operation
- Stream format, in order:
  - 16-bit word count N, low byte first.
  - N words of 4 bytes each, least-significant byte first.
  - 1 checksum byte equal to the XOR of every byte of the N data words (the header is excluded).
- Byte k of each word (k=0..3) goes to `wdata[8k+7:8k]`, so the file byte order maps directly onto RISC-V little-endian instructions.
- FSM states: `S_HDR_LO`, `S_HDR_HI`, `S_DATA`, `S_CSUM`, `S_DONE`, `S_ERR`. Reset state is `S_HDR_LO`.
- `S_HDR_LO`: on a transfer, latch count[7:0] and go to `S_HDR_HI`.
- `S_HDR_HI`: on a transfer, latch count[15:8], then:
  - if N > `IMEM_DEPTH`-`BASE_WORD`, go to `S_ERR`;
  - else if N == 0, go to `S_CSUM`;
  - else go to `S_DATA`.
- `S_DATA`:
  - Every transfer shifts a byte into the assembly register, advances the byte index (2 bits, wraps 3→0) and XORs the byte into the checksum accumulator.
  - On the 4th byte, register the write: `imem_we`=1 the next cycle with `imem_addr`=`BASE_WORD`+`word_count` and `imem_wdata`=the assembled word. `word_count` increments in that same cycle.
  - After word N, go to `S_CSUM`.
- `S_CSUM`: on a transfer, compare the byte with the accumulator. Match → `S_DONE`; mismatch → `S_ERR`.
- `S_DONE` and `S_ERR` are terminal until `reset`. `rx_ready`=0 in both.
- `rx_ready`=1 in `S_HDR_LO`, `S_HDR_HI`, `S_DATA` and `S_CSUM`. The loader never back-pressures while loading.
- Address arithmetic is `ADDR_W` bits wide; the overflow check guarantees it never wraps.

## Timing
- Reset values: `rx_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `load_done`=0, `load_error`=0, `word_count`=0, checksum accumulator=0, byte index=0.
- Write latency: `imem_we` pulses exactly one cycle, in the cycle after the transfer of a word's 4th byte.
- `rx_valid` gaps of any length stall assembly with no side effects.
- `load_done` and `core_reset` change in the cycle after the checksum transfer: `load_done` rises and `core_reset` falls.
- `load_error` rises in the cycle after the failing transfer. `core_reset` stays 1 in `S_ERR`.
- `core_reset` is a registered output and is glitch-free.
- Reset asserted mid-load:
  - All state clears asynchronously and `imem_we` drops immediately.
  - `core_reset` reasserts.
  - Partially written imem contents are left as-is; the next load overwrites them.
- The last data write and the checksum transfer may fall in adjacent cycles. The final write still completes before `core_reset` deasserts, which is at least one cycle after the final `imem_we`.

## Structure
- Shared package `boot_pkg` holds:
  - the state enum;
  - the header width constant (16);
  - the checksum-width constant (8).
- One sub-module, `byte_word_assembler`. It holds the byte index, shift register and XOR accumulator, and outputs `word_valid` (1-cycle) and `word`. The FSM, counters and imem write port stay in `imem_boot_loader`.

## Test plan
- Nominal load: header 0x0003, then words 0x00500093, 0x00A00113, 0x002081B3 sent as bytes 93 00 50 00 …, then the correct XOR.
  - Expect writes to addresses 2, 3, 4 with exactly those values.
  - Expect `word_count`=3, `load_done`=1 and `core_reset`=0 one cycle after the checksum byte.
- Same image with the checksum byte inverted.
  - Expect all 3 writes.
  - Expect `load_error`=1, `core_reset` held at 1 and `rx_ready`=0.
- Header 0x0000, checksum 0x00.
  - Expect no `imem_we` and `load_done`=1.
- Header 0x03FF (greater than 1022).
  - Expect `load_error`=1 the cycle after the header high byte, and no writes.
- Nominal image with random `rx_valid` gaps of 0–5 cycles.
  - Expect writes and results identical to the nominal load.
- Assert `reset` after 6 data bytes of a 3-word load, then reload the nominal image.
  - Expect `imem_we` to drop asynchronously and `core_reset`=1.
  - On reload, expect writes to start again at address 2 and a correct `load_done`.
